// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: FSM state encoding, response codes, default
// protection attribute. Reused by the master and slave read/write blocks.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } axi_lite_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // AXI4-Lite has no exclusive access, so EXOKAY is treated as a fault too.
    function automatic logic resp_is_fault(input logic [1:0] resp);
        logic fault;
        case (resp)
            RESP_OKAY:                              fault = 1'b0;
            RESP_EXOKAY, RESP_SLVERR, RESP_DECERR:  fault = 1'b1;
            default:                                fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/axi4_lite_master_read_if.sv
// AXI4-Lite read address/data channels with master and slave views.
interface axi4_lite_master_read_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32
);
    logic                      AR_VALID;
    logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
    logic [2:0]                AR_PROT;
    logic                      AR_READY;

    logic                      R_READY;
    logic [AXI_DATA_WIDTH-1:0] R_DATA;
    logic [1:0]                R_RESP;
    logic                      R_VALID;

    modport master (
        output AR_VALID, AR_ADDR, AR_PROT,
        input  AR_READY,
        output R_READY,
        input  R_DATA, R_RESP, R_VALID
    );

    modport slave (
        input  AR_VALID, AR_ADDR, AR_PROT,
        output AR_READY,
        input  R_READY,
        output R_DATA, R_RESP, R_VALID
    );
endinterface

// File: rtl/axi4_lite_master_read.sv
// Single-outstanding AXI4-Lite read master: IDLE -> ADDR -> DATA -> DONE.
// Define AXI4_LITE_MASTER_READ_TIMEOUT_EN to bound the wait in ADDR/DATA.
module axi4_lite_master_read
    import axi4_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      read_start_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    output logic                      read_done_o,
    output logic                      access_fault_o,
    output logic                      busy_o,
    axi4_lite_master_read_if.master   axi
);

    axi_lite_state_e           r_state;
    logic                      r_ar_valid;
    logic [AXI_ADDR_WIDTH-1:0] r_ar_addr;
    logic                      r_r_ready;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic                      r_done;
    logic                      r_fault;

    logic w_ar_hs;
    logic w_r_hs;
    logic w_tmo;

    assign w_ar_hs = r_ar_valid & axi.AR_READY;
    assign w_r_hs  = r_r_ready  & axi.R_VALID;

`ifdef AXI4_LITE_MASTER_READ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_tmo_cnt;

    // Restart on entry to ADDR (from IDLE) and on entry to DATA (AR handshake).
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_IDLE || (r_state == ST_ADDR && w_ar_hs)) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ADDR || r_state == ST_DATA) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= ST_IDLE;
            r_ar_valid <= 1'b0;
            r_ar_addr  <= '0;
            r_r_ready  <= 1'b0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (read_start_i) begin
                        r_ar_addr  <= addr_i;
                        r_ar_valid <= 1'b1;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_DATA;
                    end else if (w_tmo) begin
                        r_ar_valid <= 1'b0;
                        r_data     <= '0;
                        r_fault    <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        r_data    <= axi.R_DATA;
                        r_fault   <= resp_is_fault(axi.R_RESP);
                        r_r_ready <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_tmo) begin
                        r_r_ready <= 1'b0;
                        r_data    <= '0;
                        r_fault   <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign axi.AR_VALID   = r_ar_valid;
    assign axi.AR_ADDR    = r_ar_addr;
    assign axi.AR_PROT    = PROT_DEFAULT;
    assign axi.R_READY    = r_r_ready;

    assign data_o         = r_data;
    assign read_done_o    = r_done;
    assign access_fault_o = r_fault;
    assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi4_lite_master_read.sv
// Directed bench for axi4_lite_master_read: table of read transactions with a
// cycle-stepped slave, plus reset, mid-transaction reset and timeout sequences.
module tb_axi4_lite_master_read;

    localparam int AW = 64;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic          read_start_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_o;
    logic          read_done_o;
    logic          access_fault_o;
    logic          busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    axi4_lite_master_read_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi_if ();

    axi4_lite_master_read #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i          (clk_i),
        .arst_i         (arst_i),
        .read_start_i   (read_start_i),
        .addr_i         (addr_i),
        .data_o         (data_o),
        .read_done_o    (read_done_o),
        .access_fault_o (access_fault_o),
        .busy_o         (busy_o),
        .axi            (axi_if)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ard;       // AR_VALID cycles before AR_READY rises
        int          rd;        // R_READY cycles before R_VALID rises
        bit          poke;      // pulse read_start_i while in DATA
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_rr;    // first cycle with R_READY (-1: never)
        int          exp_done;  // cycle of read_done_o
        int          exp_hs;    // AR handshakes expected
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int cyc = 0, ar_wait = 0, r_wait = 0, done_cnt = 0, ar_hs = 0;
        int done_cyc = -1, av_cyc = -1, rr_cyc = -1;
        bit addr_bad = 0, rr_bad = 0, busy_bad = 0;
        @(negedge clk_i);
        check({tag, " idle busy"}, 64'(busy_o), 64'd0);
        check({tag, " idle done"}, 64'(read_done_o), 64'd0);
        read_start_i    = 1'b1;
        addr_i          = v.addr;
        axi_if.R_DATA   = v.rdata;
        axi_if.R_RESP   = v.rresp;
        axi_if.AR_READY = (v.ard == 0);
        axi_if.R_VALID  = (v.rd == 0);
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            read_start_i = v.poke && axi_if.R_READY;
            addr_i       = ~v.addr;
            if (!busy_o) busy_bad = 1;
            if (axi_if.AR_VALID) begin
                if (av_cyc < 0) av_cyc = cyc;
                if (axi_if.AR_ADDR !== v.addr) addr_bad = 1;
                if (axi_if.R_READY) rr_bad = 1;
                axi_if.AR_READY = (ar_wait >= v.ard);
                ar_wait++;
                if (axi_if.AR_READY) ar_hs++;
            end else begin
                axi_if.AR_READY = 1'b0;
            end
            if (axi_if.R_READY) begin
                if (rr_cyc < 0) rr_cyc = cyc;
                axi_if.R_VALID = (r_wait >= v.rd);
                r_wait++;
            end else begin
                axi_if.R_VALID = (v.rd == 0);
            end
            if (read_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        read_start_i = 1'b0;
        check({tag, " done cycle"}, 64'(done_cyc), 64'(v.exp_done));
        check({tag, " ar_valid cycle"}, 64'(av_cyc), 64'd1);
        check({tag, " r_ready cycle"}, 64'(rr_cyc), 64'(v.exp_rr));
        check({tag, " ar handshakes"}, 64'(ar_hs), 64'(v.exp_hs));
        check({tag, " data_o"}, 64'(data_o), 64'(v.exp_data));
        check({tag, " access_fault_o"}, 64'(access_fault_o), 64'(v.exp_fault));
        check({tag, " ar_addr stable"}, 64'(addr_bad), 64'd0);
        check({tag, " r_ready in addr"}, 64'(rr_bad), 64'd0);
        check({tag, " busy held"}, 64'(busy_bad), 64'd0);
        check({tag, " prot"}, 64'(axi_if.AR_PROT), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64'h1000, 32'hDEADBEEF, 2'b00, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 2, 3, 1};
        vecs[1] = '{64'h2000_0004, 32'h12345678, 2'b10, 0, 2, 1'b0, 32'h12345678, 1'b1, 2, 5, 1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'hA5A5A5A5, 2'b11, 5, 0, 1'b0, 32'hA5A5A5A5, 1'b1, 7, 8, 1};
        vecs[3] = '{64'h0, 32'h0BADF00D, 2'b01, 1, 1, 1'b0, 32'h0BADF00D, 1'b1, 3, 5, 1};
        vecs[4] = '{64'h8, 32'hFFFFFFFF, 2'b00, 3, 4, 1'b0, 32'hFFFFFFFF, 1'b0, 5, 10, 1};
        vecs[5] = '{64'h40, 32'h00C0FFEE, 2'b00, 0, 3, 1'b1, 32'h00C0FFEE, 1'b0, 2, 6, 1};

        arst_i          = 1'b1;
        read_start_i    = 1'b0;
        addr_i          = '0;
        axi_if.AR_READY = 1'b0;
        axi_if.R_VALID  = 1'b0;
        axi_if.R_DATA   = '0;
        axi_if.R_RESP   = 2'b00;
        repeat (2) @(negedge clk_i);
        check("rst ar_valid", 64'(axi_if.AR_VALID), 64'd0);
        check("rst ar_addr", axi_if.AR_ADDR, 64'd0);
        check("rst r_ready", 64'(axi_if.R_READY), 64'd0);
        check("rst data_o", 64'(data_o), 64'd0);
        check("rst done", 64'(read_done_o), 64'd0);
        check("rst fault", 64'(access_fault_o), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        arst_i = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        @(negedge clk_i);
        check("post done low", 64'(read_done_o), 64'd0);
        check("post busy low", 64'(busy_o), 64'd0);
        check("post ar_valid low", 64'(axi_if.AR_VALID), 64'd0);
        check("post data hold", 64'(data_o), 64'h00C0FFEE);

        // Reset while waiting in DATA: everything clears at once, no completion.
        begin
            bit done_seen = 0;
            read_start_i    = 1'b1;
            addr_i          = 64'h3000;
            axi_if.AR_READY = 1'b1;
            axi_if.R_VALID  = 1'b0;
            @(negedge clk_i);
            read_start_i = 1'b0;
            @(negedge clk_i);
            check("mid r_ready", 64'(axi_if.R_READY), 64'd1);
            arst_i = 1'b1;
            #1;
            check("mid rst ar_valid", 64'(axi_if.AR_VALID), 64'd0);
            check("mid rst r_ready", 64'(axi_if.R_READY), 64'd0);
            check("mid rst ar_addr", axi_if.AR_ADDR, 64'd0);
            check("mid rst data_o", 64'(data_o), 64'd0);
            check("mid rst busy", 64'(busy_o), 64'd0);
            axi_if.R_VALID = 1'b1;
            repeat (2) begin
                @(negedge clk_i);
                if (read_done_o) done_seen = 1;
            end
            arst_i = 1'b0;
            repeat (2) begin
                @(negedge clk_i);
                if (read_done_o) done_seen = 1;
            end
            check("mid rst no done", 64'(done_seen), 64'd0);
            run_txn('{64'h3000, 32'h5A5A1234, 2'b00, 2, 1, 1'b0, 32'h5A5A1234, 1'b0, 4, 6, 1},
                    "after rst");
        end

`ifdef AXI4_LITE_MASTER_READ_TIMEOUT_EN
        run_txn('{64'h4000, 32'h11111111, 2'b00, 1000000, 0, 1'b0, 32'h0, 1'b1, -1, 9, 0},
                "timeout");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_read.md
AXI4_LITE_MASTER_READ -- requirements
Module: axi4_lite_master_read

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, timeout limit used only under the macro in REQ-030.
REQ-004 clk_i  in  1  clock; all logic on the rising edge.
REQ-005 arst_i  in  1  reset, asynchronous, active-high.
REQ-006 read_start_i  in  1  one-cycle request pulse from the core/cache side.
REQ-007 addr_i  in  AXI_ADDR_WIDTH  read address, sampled with read_start_i.
REQ-008 data_o  out  AXI_DATA_WIDTH  read data of the last completed transaction.
REQ-009 read_done_o  out  1  one-cycle completion pulse.
REQ-010 access_fault_o  out  1  error status of the last completed transaction.
REQ-011 busy_o  out  1  high while the FSM is not in IDLE.
REQ-012 AR_VALID out 1; AR_ADDR out AXI_ADDR_WIDTH; AR_PROT out 3; AR_READY in 1: AXI4-Lite read address channel.
REQ-013 R_READY out 1; R_DATA in AXI_DATA_WIDTH; R_RESP in 2; R_VALID in 1: AXI4-Lite read data channel.

Function
REQ-014 SHALL implement an FSM with states IDLE, ADDR, DATA and DONE.
REQ-015 IDLE: when read_start_i=1, SHALL register addr_i into AR_ADDR, set AR_VALID=1 and go to ADDR.
REQ-016 SHALL ignore read_start_i in every state other than IDLE; requests are neither queued nor dropped silently, and busy_o=1 in those states.
REQ-017 ADDR: SHALL hold AR_VALID=1 and AR_ADDR stable until an edge with AR_VALID&AR_READY; AR_READY high before AR_VALID SHALL be legal.
REQ-018 On the AR handshake edge, SHALL clear AR_VALID, set R_READY=1 and go to DATA.
REQ-019 DATA: on an edge with R_VALID&R_READY, SHALL capture R_DATA into data_o, clear R_READY and go to DONE.
REQ-020 On that same edge, SHALL set access_fault_o=0 if R_RESP=2'b00 (OKAY) and access_fault_o=1 for 2'b10 (SLVERR), 2'b11 (DECERR) or 2'b01.
REQ-021 R_VALID asserted while in IDLE or ADDR SHALL be ignored; R_READY=0 in those states.
REQ-022 DONE: SHALL pulse read_done_o=1 for exactly one cycle, then return to IDLE.
REQ-023 A new read_start_i SHALL be accepted in the first IDLE cycle after DONE, giving back-to-back throughput of one read per 4 cycles minimum.
REQ-024 Latency: with AR_READY and R_VALID already high, read_start_i in cycle 0 SHALL produce AR_VALID in cycle 1, R_READY in cycle 2 and read_done_o in cycle 3.
REQ-025 data_o and access_fault_o SHALL hold their values until the next completion.
REQ-026 AR_PROT SHALL be constant 3'b000.
REQ-027 busy_o SHALL equal (state != IDLE), decoded combinationally from the state register.

Reset
REQ-028 While arst_i=1: state=IDLE; AR_VALID, R_READY, read_done_o and access_fault_o = 0; AR_ADDR and data_o = 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction, with no read_done_o pulse; recovery is the responsibility of the system.

Configuration
REQ-030 With AXI4_LITE_MASTER_READ_TIMEOUT_EN defined, a counter SHALL clear on entry to ADDR and DATA, increment each cycle spent in either state, and on reaching TIMEOUT_CYCLES-1 without a handshake force DONE with AR_VALID=0, R_READY=0, data_o=0 and access_fault_o=1.
REQ-031 Without AXI4_LITE_MASTER_READ_TIMEOUT_EN, no counter SHALL exist and the FSM SHALL wait indefinitely in ADDR/DATA.

Structure
REQ-032 The FSM state enum and the AXI response constants (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) SHALL live in shared package axi4_lite_pkg, reused by the slave read/write blocks.
REQ-033 No sub-module is required; the timeout counter SHALL be inline logic under the macro.

Verification
REQ-034 AR_READY=1, R_VALID=1 with R_RESP=00 and R_DATA=0xDEADBEEF; read_start_i with addr 0x1000 -> AR_ADDR=0x1000 in cycle 1, read_done_o in cycle 3, data_o=0xDEADBEEF, access_fault_o=0.
REQ-035 AR_READY delayed 5 cycles -> AR_VALID and AR_ADDR stable for all 6 cycles, R_READY=0 throughout ADDR.
REQ-036 R_RESP=2'b10 with R_DATA=0x12345678 -> data_o=0x12345678, access_fault_o=1, single read_done_o pulse.
REQ-037 read_start_i pulsed while in DATA -> ignored; exactly one AR handshake observed.
REQ-038 arst_i asserted in DATA -> all outputs 0 immediately and no read_done_o; a subsequent read completes normally.
REQ-039 Macro on, TIMEOUT_CYCLES=8, AR_READY held 0 -> read_done_o after 8 ADDR cycles with access_fault_o=1 and data_o=0.
